icache_fetch: RTL and testbench

- Instruction-side responder for the PC block. It accepts the fetch address the PC presents and returns the instruction word with `iready`, which lets the PC advance.
- Contains a small direct-mapped instruction cache, one word per line.
- On a miss it runs a single-outstanding read on the instruction memory bus, fills the line, then answers from the cache.
- Sits between `pc` and the instruction memory/bus arbiter.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_array.sv | 53 +++++
 rtl/icache_fetch.sv | 125 ++++++++++++
 tb/tb_icache_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction-fetch cache.
//   fetch_state_t : fill FSM states (IDLE / FETCH)
//   line_t        : one cache line as seen on the array read port
//   IDX_W/TAG_W   : index/tag widths for the default 16-line, 32-bit build
//   TAG_MAX_W     : widest tag any legal build can need (2 lines). Stored
//                   tags are zero-extended to it so one line_t fits all sizes.
package icache_pkg;

  localparam int NUM_LINES_DEF = 16;
  localparam int ADDR_W_DEF    = 32;

  localparam int IDX_W     = $clog2(NUM_LINES_DEF);
  localparam int TAG_W     = ADDR_W_DEF - 2 - IDX_W;
  localparam int TAG_MAX_W = ADDR_W_DEF - 3;

  // Bubble encoding (addi x0,x0,0) used by the pipeline when it inserts its
  // own NOPs. This block outputs 0 while iready is low, not this value.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          data;
  } line_t;

endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped line storage, one 32-bit word per line.
//   clk, nRST   : clock, asynchronous active-low reset (valid bits only)
//   rd_idx_i    : asynchronous read index
//   rd_line_o   : {valid, tag, data} of line rd_idx_i
//   we_i        : write line wr_idx_i with wr_tag_i / wr_data_i, set valid
//   flush_i     : clear every valid bit; beats a same-cycle write
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IW        = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [IW-1:0]        rd_idx_i,
  output line_t                rd_line_o,
  input  logic                 we_i,
  input  logic [IW-1:0]        wr_idx_i,
  input  logic [TAG_MAX_W-1:0] wr_tag_i,
  input  logic [31:0]          wr_data_i,
  input  logic                 flush_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_MAX_W-1:0] tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data carry no reset; valid qualifies them.
  always_ff @(posedge clk) begin
    if (we_i && !flush_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_line_o       = '0;
    rd_line_o.valid = valid_q[rd_idx_i];
    rd_line_o.tag   = tag_q[rd_idx_i];
    rd_line_o.data  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: instruction-side responder for the PC block with a small
// direct-mapped cache (one word per line) and a single-outstanding miss fill.
//   clk, nRST            : clock, asynchronous active-low reset
//   pc, fetch_en         : fetch address (bits [1:0] ignored) and request
//   flush                : invalidate all lines
//   instr, iready        : instruction word, valid only with iready (else 0)
//   mem_read, mem_addr   : bus read request / word-aligned address
//   mem_rdata, mem_ack   : bus read data and completion
//   hit_count, miss_count: saturating hit-cycle / serviced-miss counters
// Hits answer combinationally in the cycle pc is presented; a miss costs
// one detect cycle plus the bus FETCH cycles, then the line hits.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              iready,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IW = $clog2(NUM_LINES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-3:0] miss_addr_q, miss_addr_d;   // word address of the miss
  logic              flushed_q, flushed_d;       // flush seen while FETCH
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  line_t                rd_line;
  logic [TAG_MAX_W-1:0] pc_tag;
  logic                 hit;
  logic                 fill_we;

  // pc[1:0] never selects anything in a word-granular cache.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc[1:0];

  assign pc_tag = TAG_MAX_W'(pc[ADDR_W-1:2+IW]);

  icache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk       (clk),
    .nRST      (nRST),
    .rd_idx_i  (pc[2+IW-1:2]),
    .rd_line_o (rd_line),
    .we_i      (fill_we),
    .wr_idx_i  (miss_addr_q[IW-1:0]),
    .wr_tag_i  (TAG_MAX_W'(miss_addr_q[ADDR_W-3:IW])),
    .wr_data_i (mem_rdata),
    .flush_i   (flush)
  );

  assign hit = (state_q == IDLE) && fetch_en && rd_line.valid &&
               (rd_line.tag == pc_tag) && !flush;

  assign iready   = hit;
  assign instr    = hit ? rd_line.data : '0;
  assign mem_read = (state_q == FETCH);
  assign mem_addr = mem_read ? {miss_addr_q, 2'b00} : '0;

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    flushed_d   = flushed_q;
    fill_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        if (fetch_en && !hit && !flush) begin
          state_d     = FETCH;
          miss_addr_d = pc[ADDR_W-1:2];
        end
      end
      FETCH: begin
        // The bus read is never abandoned; a flush only poisons its data.
        if (flush) flushed_d = 1'b1;
        if (mem_ack) begin
          fill_we   = !flushed_q;   // same-cycle flush is blocked in the array
          flushed_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      flushed_q   <= flushed_d;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == FETCH) && mem_ack && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] pc;
  logic        fetch_en, flush;
  logic [31:0] instr;
  logic        iready, mem_read;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  icache_fetch #(.NUM_LINES(16), .ADDR_W(32)) dut (
    .clk(clk), .nRST(nRST), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .instr(instr), .iready(iready), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct { logic [31:0] addr; int waitc; } bus_t;

  int          checks = 0, failures = 0;
  bus_t        exp_bus[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] exp_hits, exp_misses;
  bit          spur;
  int          bus_cnt;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h00A0_0093;
      32'h0000_2220: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_counts();
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
  endtask

  // Response monitor: every iready cycle consumes one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (iready) begin
        if (exp_rsp.size() == 0) chk("unexpected_iready", {31'b0, iready}, 32'd0);
        else chk("instr", instr, exp_rsp.pop_front());
      end else begin
        chk("instr_zero_when_not_ready", instr, 32'd0);
      end
    end
  end

  // Bus responder / request checker.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; bus_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_read) begin
        if (exp_bus.size() == 0) begin
          chk("unexpected_mem_read_addr", mem_addr, 32'hFFFF_FFFF);
          mem_ack = 1'b1; mem_rdata = memword(mem_addr); bus_cnt = 0;
        end else begin
          chk("mem_addr", mem_addr, exp_bus[0].addr);
          if (bus_cnt >= exp_bus[0].waitc) begin
            mem_ack = 1'b1; mem_rdata = memword(mem_addr);
            void'(exp_bus.pop_front());
            bus_cnt = 0;
          end else bus_cnt++;
        end
      end else begin
        bus_cnt = 0;
        if (spur) begin
          mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; spur = 1'b0;
        end
      end
    end
  end

  // Present address a for `hold` ready cycles; checks the miss latency.
  task automatic access(input logic [31:0] a, input bit miss, input int waitc, input int hold);
    int got = 0, idle = 0;
    logic [31:0] wa = {a[31:2], 2'b00};
    pc = a; fetch_en = 1'b1;
    if (miss) begin
      exp_bus.push_back('{addr: wa, waitc: waitc});
      exp_misses = sat_inc(exp_misses);
    end
    repeat (hold) begin
      exp_rsp.push_back(memword(wa));
      exp_hits = sat_inc(exp_hits);
    end
    while (got < hold && idle < 64) begin
      @(negedge clk);
      if (iready) got++; else idle++;
    end
    chk("latency", idle, miss ? waitc + 2 : 0);
    @(posedge clk); #1;
  endtask

  // Miss on a, then raise flush for one cycle in the first FETCH cycle.
  task automatic flush_miss(input logic [31:0] a, input int waitc);
    int t = 0;
    pc = a; fetch_en = 1'b1;
    exp_bus.push_back('{addr: {a[31:2], 2'b00}, waitc: waitc});
    exp_misses = sat_inc(exp_misses);
    @(posedge clk); #1;
    flush = 1'b1; fetch_en = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    while (exp_bus.size() != 0 && t < 64) begin @(posedge clk); t++; end
    chk("flush_fill_drained", exp_bus.size(), 32'd0);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    fetch_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    nRST = 1'b0; pc = '0; fetch_en = 1'b1; flush = 1'b0; spur = 1'b0;
    exp_hits = '0; exp_misses = '0;

    // Reset holds everything quiet even with a fetch requested.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iready", {31'b0, iready}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    @(posedge clk); #1;
    nRST = 1'b1;
    access(32'h0, 1'b1, 0, 1);

    // Cold miss with two bus wait cycles, then hits while pc holds.
    access(32'h40, 1'b1, 2, 3);
    chk_counts();
    chk("hits_after_cold", hit_count, 32'd4);

    // Conflict eviction on index 0.
    access(32'h80, 1'b1, 0, 1);
    access(32'h40, 1'b1, 0, 1);
    chk("miss_count_conflict", miss_count, 32'd4);

    // Idle: spurious ack must be ignored, no bus traffic, no iready.
    spur = 1'b1;
    idle_cycles(3);
    access(32'h40, 1'b0, 0, 2);
    chk_counts();

    // Sequential stream, then revisit as pure hits.
    access(32'h1234, 1'b1, 1, 1);
    access(32'h1238, 1'b1, 0, 1);
    access(32'h123C, 1'b1, 0, 1);
    access(32'h1234, 1'b0, 0, 2);
    access(32'h1238, 1'b0, 0, 2);
    access(32'h123C, 1'b0, 0, 2);
    access(32'h1236, 1'b0, 0, 1);
    chk_counts();

    // Flush during a multi-cycle FETCH: data discarded, all lines gone.
    flush_miss(32'h2222, 3);
    chk_counts();
    access(32'h2220, 1'b1, 0, 1);
    access(32'h1234, 1'b1, 0, 1);
    access(32'h40, 1'b1, 0, 1);

    // Flush in the same cycle as the fill ack: line stays invalid.
    flush_miss(32'h80, 0);
    access(32'h80, 1'b1, 0, 1);

    // Flush on a hitting line in IDLE: no iready, no miss started.
    pc = 32'h80; fetch_en = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_iready", {31'b0, iready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    access(32'h80, 1'b1, 0, 1);
    chk_counts();

    // Hit counter saturation from a preloaded value.
    fetch_en = 1'b0;
    force dut.hit_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.hit_cnt_q;
    exp_hits = 32'hFFFF_FFFD;
    access(32'h80, 1'b0, 0, 4);
    chk("hit_count_saturated", hit_count, 32'hFFFF_FFFF);
    chk_counts();

    // Reset in the middle of a FETCH drops the request at once.
    pc = 32'h300; fetch_en = 1'b1;
    exp_bus.push_back('{addr: 32'h300, waitc: 20});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fetch_mem_read", {31'b0, mem_read}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_hit_count", hit_count, 32'd0);
    exp_bus.delete();
    exp_hits = '0; exp_misses = '0;
    fetch_en = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
    access(32'h80, 1'b1, 0, 1);
    chk_counts();

    idle_cycles(2);
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
